// File: rtl/stream_fifo.sv
// stream_fifo: circular-buffer FIFO with first-word-fall-through output,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// a high-watermark occupancy monitor.
//
// Handshake: a word moves across an interface on a rising clk edge exactly
// when valid and ready are both high in that cycle. s_ready and m_valid are
// decoded only from the registered occupancy, so neither depends on s_valid
// or m_ready. The producer holds s_data while s_valid is high and s_ready is
// low; m_data is the head entry whenever m_valid is high.
module stream_fifo #(
    parameter int unsigned W        = 10,
    parameter int unsigned D        = 2,
    parameter int unsigned AF_LEVEL = (1 << D) - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready,
    output logic [D:0]   data_count,
    output logic         empty,
    output logic         full,
    output logic         almost_full,
    output logic         almost_empty,
    input  logic         wm_clr,
    output logic [D:0]   watermark
);

    localparam int unsigned DEPTH   = 1 << D;
    // Thresholds are compared at the width of the count so that a count of
    // DEPTH is representable and never wraps.
    localparam logic [D:0]   DEPTH_C = (D+1)'(DEPTH);
    localparam logic [D:0]   AF_C    = (D+1)'(AF_LEVEL);
    localparam logic [D:0]   AE_C    = (D+1)'(AE_LEVEL);
    localparam logic [D:0]   CNT_ONE = (D+1)'(1);
    localparam logic [D-1:0] PTR_ONE = D'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [D-1:0] wr_ptr_q, wr_ptr_d;
    logic [D-1:0] rd_ptr_q, rd_ptr_d;
    logic [D:0]   count_q, count_d;
    logic [D:0]   wm_q, wm_d;
    logic         push, pop;

    // Flags and handshake outputs decode from the registered count only.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign s_ready      = ~full;
    assign m_valid      = ~empty;
    assign m_data       = mem_q[rd_ptr_q];
    assign data_count   = count_q;
    assign watermark    = wm_q;

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    // Next pointers and count; flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Watermark tracks the peak of the next occupancy; clearing reloads it
    // with the next occupancy so words already held are still accounted for.
    always_comb begin
        wm_d = wm_q;
        if (wm_clr) begin
            wm_d = count_d;
        end else if (count_d > wm_q) begin
            wm_d = count_d;
        end
    end

    // Pointer, count and watermark registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wm_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wm_q     <= wm_d;
        end
    end

    // Storage array: cleared on reset, written on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (W=8, D=2, AF_LEVEL=3, AE_LEVEL=1).
// The driver pushes each word it expects to be accepted into exp_q; a
// forked monitor pops and compares whenever the output handshake completes.
module tb_stream_fifo;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic [D:0]   data_count;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic         almost_empty;
  logic         wm_clr;
  logic [D:0]   watermark;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  stream_fifo #(
    .W        (W),
    .D        (D),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .data_count   (data_count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wm_clr       (wm_clr),
    .watermark    (watermark)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_count"},   32'(data_count),   32'd0);
    check({tag, " m_valid"},      32'(m_valid),      32'd0);
    check({tag, " m_data"},       32'(m_data),       32'd0);
    check({tag, " s_ready"},      32'(s_ready),      32'd1);
    check({tag, " empty"},        32'(empty),        32'd1);
    check({tag, " full"},         32'(full),         32'd0);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " almost_full"},  32'(almost_full),  32'd0);
    check({tag, " watermark"},    32'(watermark),    32'd0);
  endtask

  // scoreboard monitor: sampled on the falling edge, where inputs are stable
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid === 1'b1 && m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no word at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e));
        end
      end
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    exp_q.push_back(d);
  endtask

  initial begin
    logic [W-1:0] fill_vals [4];
    n_checks = 0;
    n_fail   = 0;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    wm_clr  = 1'b0;
    fork
      monitor();
    join_none

    // reset values
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // fill to full with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      push_word(fill_vals[i]);
      tick();
      check("fill count",        32'(data_count),   32'(i + 1));
      check("fill almost_full",  32'(almost_full),  32'((i + 1) >= 3));
      check("fill full",         32'(full),         32'((i + 1) == 4));
      check("fill s_ready",      32'(s_ready),      32'((i + 1) != 4));
      check("fill almost_empty", 32'(almost_empty), 32'((i + 1) <= 1));
    end
    check("fill watermark", 32'(watermark), 32'd4);

    // push attempt while full alongside a pop: only the pop happens
    s_valid = 1'b1;
    s_data  = 8'h55;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("full pop count",   32'(data_count), 32'd3);
    check("full pop s_ready", 32'(s_ready),    32'd1);
    repeat (3) tick();
    m_ready = 1'b0;
    check("drain empty",   32'(empty),         32'd1);
    check("drain m_valid", 32'(m_valid),       32'd0);
    check("drain queue",   32'(exp_q.size()),  32'd0);

    // fall-through latency, then sustained push+pop across pointer wrap
    push_word(8'hA5);
    check("latency m_valid cycle N", 32'(m_valid), 32'd0);
    tick();
    check("latency m_valid cycle N+1", 32'(m_valid), 32'd1);
    check("latency m_data cycle N+1",  32'(m_data),  32'hA5);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_word(8'hB0 + 8'(i));
      tick();
      check("stream count", 32'(data_count), 32'd1);
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("stream end count", 32'(data_count), 32'd0);

    // flush overrides push and pop; watermark survives flush
    wm_clr = 1'b1;
    tick();
    wm_clr = 1'b0;
    check("wm_clr empty", 32'(watermark), 32'd0);
    push_word(8'hC1); tick();
    push_word(8'hC2); tick();
    push_word(8'hC3); tick();
    check("prefill count", 32'(data_count), 32'd3);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;
    exp_q.delete();
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("flush count",     32'(data_count), 32'd0);
    check("flush empty",     32'(empty),      32'd1);
    check("flush m_valid",   32'(m_valid),    32'd0);
    check("flush s_ready",   32'(s_ready),    32'd1);
    check("flush watermark", 32'(watermark),  32'd3);
    wm_clr = 1'b1;
    tick();
    wm_clr = 1'b0;
    check("wm_clr after flush", 32'(watermark), 32'd0);

    // wm_clr loads the next occupancy, not zero
    push_word(8'hD1); tick();
    push_word(8'hD2); tick();
    check("wm at count 2", 32'(watermark), 32'd2);
    push_word(8'hD3);
    wm_clr = 1'b1;
    tick();
    s_valid = 1'b0;
    check("wm_clr with push", 32'(watermark),  32'd3);
    check("count 3",          32'(data_count), 32'd3);
    m_ready = 1'b1;
    tick();
    wm_clr  = 1'b0;
    m_ready = 1'b0;
    check("wm_clr with pop", 32'(watermark),  32'd2);
    check("count 2",         32'(data_count), 32'd2);

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async reset");
    #2 rst_n = 1'b1;
    tick();
    push_word(8'h7E);
    tick();
    s_valid = 1'b0;
    check("post reset count",   32'(data_count), 32'd1);
    check("post reset m_valid", 32'(m_valid),    32'd1);
    check("post reset m_data",  32'(m_data),     32'h7E);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    check("final queue", 32'(exp_q.size()), 32'd0);
    check("final empty", 32'(empty),        32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised successor to the shift-register FIFO used in the dvp datapath.
- Circular-buffer FIFO with a valid/ready handshake on both sides and first-word-fall-through output.
- Adds programmable almost-full/almost-empty thresholds, synchronous flush and a high-watermark occupancy monitor.
- Sits between pixel/feature producers and consumers that can stall independently.

Parameters:
- W, 10, data width in bits.
- D, 2, log2 of depth; capacity DEPTH = 2^D entries.
- AF_LEVEL, 2^D-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents and count.
- s_valid  in  1  write request.
- s_data  in  W  write data.
- s_ready  out  1  FIFO can accept; equals ~full.
- m_valid  out  1  head entry is valid; equals ~empty.
- m_data  out  W  head entry, fall-through.
- m_ready  in  1  consumer accepts the head.
- data_count  out  D+1  current occupancy, 0..DEPTH.
- empty  out  1  data_count == 0.
- full  out  1  data_count == DEPTH.
- almost_full  out  1  data_count >= AF_LEVEL.
- almost_empty  out  1  data_count <= AE_LEVEL.
- wm_clr  in  1  clear high watermark.
- watermark  out  D+1  maximum data_count reached since reset or last wm_clr.

Behaviour:
- Storage: DEPTH x W register array; wr_ptr and rd_ptr are D bits each and wrap modulo DEPTH naturally. data_count is a separate D+1 bit register.
- Push = s_valid & s_ready. Pop = m_valid & m_ready.
- s_ready, m_valid and all flags decode combinationally from registered data_count only. There is no combinational path from s_valid or m_ready to any output.
- m_data = mem[rd_ptr] (asynchronous read).
- Latency: a word pushed into an empty FIFO in cycle N appears on m_data with m_valid=1 in cycle N+1.
- Push only: mem[wr_ptr] <= s_data, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- When full, s_ready=0, so no push occurs even if a pop happens that cycle; s_ready rises the cycle after the pop.
- When empty, m_valid=0, so no pop occurs; a same-cycle push is not bypassed.
- Overflow and underflow are structurally impossible. s_valid while full, or m_ready while empty, is ignored with no state change.
- flush=1: next cycle wr_ptr=rd_ptr=0 and count=0. Flush overrides any push or pop in the same cycle. Storage contents are not cleared.
- Watermark:
  - Each cycle, watermark <= max(watermark, next_count).
  - wm_clr=1: watermark <= next_count (not 0), so the current occupancy is never lost.
  - flush does not clear the watermark.
- Reset, async on rst_n low:
  - Pointers 0, data_count 0, watermark 0, storage 0.
  - Therefore m_data=0, m_valid=0, s_ready=1, empty=1, full=0, almost_empty=1.
  - almost_full=0 (AF_LEVEL>=1).
  - Reset mid-transfer discards all contents immediately.
- Width rules: the count compares against AF_LEVEL/AE_LEVEL at D+1 bits. Reaching DEPTH must not wrap data_count.

Test Plan (W=8, D=2, AF_LEVEL=3, AE_LEVEL=1):
- Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles with m_ready=0 -> count 1,2,3,4; almost_full at count 3; full=1 and s_ready=0 at count 4; almost_empty=0 from count 2; watermark=4.
- From full, hold s_valid=1 with 0x55 and m_ready=1 for one cycle -> pop of 0x11 only, count=3, 0x55 not stored; next cycle s_ready=1. Then drain -> order 0x22,0x33,0x44, then empty=1, m_valid=0.
- Empty FIFO: push 0xA5 in cycle N -> m_valid=1 and m_data=0xA5 in cycle N+1, not N. Then sustained push+pop with m_ready=1 for 20 cycles -> count stays 1, data in order, pointers wrap past 3 correctly.
- Fill to 3, assert flush together with s_valid and m_ready -> next cycle count=0, empty=1, m_valid=0, s_ready=1; watermark stays 3. Then wm_clr -> watermark=0.
- With count=2, assert wm_clr and a push in the same cycle -> watermark=3 next cycle.
- Drop rst_n asynchronously mid-burst at count=2 -> outputs reach reset values without a clock edge. After release, the first push yields the correct data with no stale entry.
